// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC/nPC fetch sequencer.
// Optional feature macro: PC_SEQ_TRAP_EN (trap entry and FLUSH state).
package pc_seq_pkg;

   // FLUSH is only reachable when PC_SEQ_TRAP_EN is defined.
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      SLOT  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   // Which ID-stage source supplied the redirect target.
   typedef enum logic [1:0] {
      NONE = 2'd0,
      JMPL = 2'd1,
      CALL = 2'd2,
      BR   = 2'd3
   } redirect_src_t;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // Clear the byte-offset bits so a target is always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target selection: Jmpl > Call > taken branch, with word
// alignment of the winner and a flag for a non-aligned request.
// Optional feature macro: PC_SEQ_TRAP_EN (not used in this file).
module pc_target_sel
   import pc_seq_pkg::*;
(
   input  logic        jmpl,
   input  logic        call,
   input  logic        branch_taken,
   input  logic [31:0] alu_out,
   input  logic [31:0] ta,
   output logic        redirect,
   output logic [31:0] target,
   output logic        misalign
);

   redirect_src_t src;
   logic [31:0]   raw_target;

   // Fixed-priority pick of the redirect source and its raw target.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      src        = NONE;
      raw_target = ta;
      if (jmpl) begin
         src        = JMPL;
         raw_target = alu_out;
      end else if (call) begin
         src = CALL;
      end else if (branch_taken) begin
         src = BR;
      end
   end

   assign redirect = (src != NONE);
   assign target   = word_align(raw_target);
   assign misalign = redirect && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_npc_sequencer.sv
// Architectural PC/nPC owner and fetch sequencer with SPARC delayed
// control transfer, annul squashing and hazard stalls.
// Optional feature macro: PC_SEQ_TRAP_EN adds trap_req/trap_vec and FLUSH.
module pc_npc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        clr,
   input  logic        stall,
   input  logic        ID_jmpl_instr,
   input  logic        ID_call_instr,
   input  logic        branch_taken,
   input  logic        ID_branch_instr,
   input  logic        ID_annul,
   input  logic        ID_branch_always,
   input  logic [31:0] ALU_OUT,
   input  logic [31:0] TA,
`ifdef PC_SEQ_TRAP_EN
   input  logic        trap_req,
   input  logic [31:0] trap_vec,
`endif
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic        fetch_valid,
   output logic        if_flush,
   output logic        misalign
);

   state_t      state, state_next;
   logic [31:0] pc_next, npc_next;
   logic        fetch_valid_next, misalign_next;
   logic        redirect, target_misalign, annul_squash;
   logic [31:0] target;

   pc_target_sel u_target_sel (
      .jmpl         (ID_jmpl_instr),
      .call         (ID_call_instr),
      .branch_taken (branch_taken),
      .alu_out      (ALU_OUT),
      .ta           (TA),
      .redirect     (redirect),
      .target       (target),
      .misalign     (target_misalign)
   );

   // Annulling Bicc squashes its delay slot when not taken, or always for BA,a.
   assign annul_squash = ID_branch_instr & ID_annul & (~branch_taken | ID_branch_always);

   // Next-state, next PC/nPC and the zero-latency IF flush.
   always_comb begin
      state_next       = state;
      pc_next          = pc;
      npc_next         = npc;
      fetch_valid_next = fetch_valid;
      misalign_next    = 1'b0;
      if_flush         = 1'b0;
      if (!stall) begin
         case (state)
            BOOT: begin
               state_next       = RUN;
               fetch_valid_next = 1'b1;
            end
            FLUSH: begin
               if_flush         = annul_squash;
               state_next       = RUN;
               fetch_valid_next = 1'b1;
            end
            default: begin
               if_flush         = annul_squash;
               fetch_valid_next = 1'b1;
               pc_next          = npc;
               if (redirect) begin
                  npc_next      = target;
                  state_next    = SLOT;
                  misalign_next = target_misalign;
               end else begin
                  npc_next   = npc + INSTR_BYTES;
                  state_next = RUN;
               end
            end
         endcase
      end
`ifdef PC_SEQ_TRAP_EN
      if (trap_req) begin
         pc_next          = trap_vec;
         npc_next         = trap_vec + INSTR_BYTES;
         state_next       = FLUSH;
         fetch_valid_next = 1'b0;
         misalign_next    = 1'b0;
         if_flush         = 1'b1;
      end
`endif
   end

   // State and architectural registers; clr overrides every other input.
   always_ff @(posedge clk) begin
      // NOTE: control state is reset explicitly here; plain data paths elsewhere need not be.
      if (clr) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         npc         <= RESET_PC + INSTR_BYTES;
         fetch_valid <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         state       <= state_next;
         pc          <= pc_next;
         npc         <= npc_next;
         fetch_valid <= fetch_valid_next;
         misalign    <= misalign_next;
      end
   end

endmodule
